// File: rtl/trng_ctrl.sv
// trng_ctrl: sequencing controller for the ring-oscillator TRNG macro.
// Warms up the oscillators, samples the raw bit at a programmable rate,
// optionally applies von Neumann debiasing, packs bits into a word on a
// valid/ready interface and runs a repetition-count health test.
module trng_ctrl #(
  parameter int WIDTH         = 32,
  parameter int WARMUP_CYCLES = 256,
  parameter int SAMPLE_DIV    = 4,
  parameter int REP_LIMIT     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             debias_en,
  output logic             trng_en,
  input  logic             trng_bit,
  output logic [WIDTH-1:0] rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             busy,
  output logic             health_fail
);

  localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);

  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(WIDTH);
  localparam logic [RW-1:0] REP_MAX   = RW'(REP_LIMIT);
  localparam logic [RW-1:0] REP_ONE   = RW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_COLLECT = 2'd2,
    ST_FULL    = 2'd3
  } state_t;

  state_t          state_r;
  logic [WW-1:0]   warm_cnt_r;
  logic [DW-1:0]   div_r;
  logic [CW-1:0]   bit_cnt_r;
  logic [RW-1:0]   rep_cnt_r;
  logic            last_bit_r;
  logic            pair_r;
  logic            pair_bit_r;
  logic            debias_r;

  logic            strobe_s;
  logic            abort_s;
  logic            trip_s;
  logic            shift_s;
  logic            shift_bit_s;
  logic            word_done_s;
  logic [RW-1:0]   rep_next_s;
  logic [CW-1:0]   cnt_next_s;

  // Decode the sample strobe, health-test update and debias/pack decision.
  always_comb begin
    strobe_s    = (state_r == ST_COLLECT) && (div_r == DIV_LAST);
    abort_s     = (state_r != ST_IDLE) && !enable;
    shift_s     = 1'b0;
    shift_bit_s = trng_bit;
    if ((rep_cnt_r == {RW{1'b0}}) || (trng_bit != last_bit_r)) begin
      rep_next_s = REP_ONE;
    end else begin
      rep_next_s = rep_cnt_r + REP_ONE;
    end
    // A disable already sends us to IDLE, so a trip only counts while enabled.
    trip_s = strobe_s && enable && (rep_next_s == REP_MAX);
    if (strobe_s) begin
      if (!debias_r) begin
        shift_s     = 1'b1;
        shift_bit_s = trng_bit;
      end else if (pair_r) begin
        shift_s     = (pair_bit_r != trng_bit);
        shift_bit_s = pair_bit_r;
      end else begin
        shift_s     = 1'b0;
        shift_bit_s = trng_bit;
      end
    end else begin
      shift_s     = 1'b0;
      shift_bit_s = trng_bit;
    end
    cnt_next_s  = bit_cnt_r + {{(CW-1){1'b0}}, shift_s};
    word_done_s = shift_s && (cnt_next_s == CNT_FULL);
  end

  // Sequencing FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      warm_cnt_r  <= {WW{1'b0}};
      div_r       <= {DW{1'b0}};
      bit_cnt_r   <= {CW{1'b0}};
      rep_cnt_r   <= {RW{1'b0}};
      last_bit_r  <= 1'b0;
      pair_r      <= 1'b0;
      pair_bit_r  <= 1'b0;
      debias_r    <= 1'b0;
      trng_en     <= 1'b0;
      rnd_data    <= {WIDTH{1'b0}};
      rnd_valid   <= 1'b0;
      busy        <= 1'b0;
      health_fail <= 1'b0;
    end else if (abort_s || trip_s) begin
      // Disable or health trip: drop everything and return to IDLE.
      state_r     <= ST_IDLE;
      warm_cnt_r  <= {WW{1'b0}};
      div_r       <= {DW{1'b0}};
      bit_cnt_r   <= {CW{1'b0}};
      rep_cnt_r   <= {RW{1'b0}};
      last_bit_r  <= 1'b0;
      pair_r      <= 1'b0;
      pair_bit_r  <= 1'b0;
      trng_en     <= 1'b0;
      rnd_data    <= {WIDTH{1'b0}};
      rnd_valid   <= 1'b0;
      busy        <= 1'b0;
      health_fail <= health_fail | trip_s;
    end else begin
      case (state_r)
        ST_IDLE: begin
          trng_en   <= 1'b0;
          rnd_valid <= 1'b0;
          busy      <= 1'b0;
          if (enable && !health_fail) begin
            state_r    <= ST_WARMUP;
            warm_cnt_r <= {WW{1'b0}};
            debias_r   <= debias_en;
            trng_en    <= 1'b1;
            busy       <= 1'b1;
          end else if (!enable) begin
            health_fail <= 1'b0;
          end
        end
        ST_WARMUP: begin
          if (warm_cnt_r == WARM_LAST) begin
            state_r    <= ST_COLLECT;
            warm_cnt_r <= {WW{1'b0}};
            div_r      <= {DW{1'b0}};
            bit_cnt_r  <= {CW{1'b0}};
            rep_cnt_r  <= {RW{1'b0}};
            pair_r     <= 1'b0;
          end else begin
            warm_cnt_r <= warm_cnt_r + {{(WW-1){1'b0}}, 1'b1};
          end
        end
        ST_COLLECT: begin
          if (div_r == DIV_LAST) begin
            div_r <= {DW{1'b0}};
          end else begin
            div_r <= div_r + {{(DW-1){1'b0}}, 1'b1};
          end
          if (strobe_s) begin
            last_bit_r <= trng_bit;
            rep_cnt_r  <= rep_next_s;
            if (debias_r) begin
              if (!pair_r) begin
                pair_bit_r <= trng_bit;
                pair_r     <= 1'b1;
              end else begin
                pair_r <= 1'b0;
              end
            end
          end
          if (shift_s) begin
            rnd_data  <= {rnd_data[WIDTH-2:0], shift_bit_s};
            bit_cnt_r <= cnt_next_s;
          end
          if (word_done_s) begin
            state_r   <= ST_FULL;
            rnd_valid <= 1'b1;
            busy      <= 1'b0;
            div_r     <= {DW{1'b0}};
            pair_r    <= 1'b0;
          end
        end
        ST_FULL: begin
          if (rnd_ready) begin
            state_r   <= ST_COLLECT;
            rnd_valid <= 1'b0;
            rnd_data  <= {WIDTH{1'b0}};
            bit_cnt_r <= {CW{1'b0}};
            rep_cnt_r <= {RW{1'b0}};
            div_r     <= {DW{1'b0}};
            busy      <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          trng_en   <= 1'b0;
          rnd_valid <= 1'b0;
          rnd_data  <= {WIDTH{1'b0}};
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
